// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter family: boundary mode and count direction encodings.
package counter_pkg;

  localparam bit MODE_WRAP = 1'b0;
  localparam bit MODE_SAT  = 1'b1;

  localparam bit DIR_UP   = 1'b0;
  localparam bit DIR_DOWN = 1'b1;

endpackage

// File: rtl/counter_next.sv
// Next-count logic: one step up or down within 0..MAX, with wrap or hold at the boundary.
module counter_next
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH    = 4,
  parameter logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}},
  parameter bit               SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] cnt_i,
  input  logic             down_i,
  output logic [WIDTH-1:0] cnt_next_o,
  output logic             boundary_o
);

  logic at_max;
  logic at_zero;

  assign at_max  = (cnt_i == MAX);
  assign at_zero = (cnt_i == '0);

  always_comb begin
    cnt_next_o = cnt_i;
    boundary_o = 1'b0;
    if (down_i == DIR_DOWN) begin
      boundary_o = at_zero;
      if (at_zero) begin
        cnt_next_o = (SATURATE == MODE_SAT) ? '0 : MAX;
      end else begin
        cnt_next_o = cnt_i - WIDTH'(1);
      end
    end else begin
      boundary_o = at_max;
      // Compare against MAX, not the natural rollover, so non-power-of-two moduli wrap correctly.
      if (at_max) begin
        cnt_next_o = (SATURATE == MODE_SAT) ? MAX : '0;
      end else begin
        cnt_next_o = cnt_i + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/param_up_down_counter.sv
// Parametrised up/down counter with modulus, enable, parallel load, wrap/saturate mode,
// combinational terminal count and a registered one-cycle overflow pulse.
module param_up_down_counter
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH    = 4,
  parameter logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}},
  parameter bit               SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             ovf
);

  logic [WIDTH-1:0] out_q, out_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] cnt_next;
  logic             boundary;
  logic [WIDTH-1:0] load_clamped;

  counter_next #(
    .WIDTH    (WIDTH),
    .MAX      (MAX),
    .SATURATE (SATURATE)
  ) u_counter_next (
    .cnt_i      (out_q),
    .down_i     (down),
    .cnt_next_o (cnt_next),
    .boundary_o (boundary)
  );

  assign load_clamped = (load_val > MAX) ? MAX : load_val;

  always_comb begin
    out_d = out_q;
    ovf_d = 1'b0;
    if (load) begin
      out_d = load_clamped;
    end else if (en) begin
      out_d = cnt_next;
      ovf_d = boundary;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      ovf_q <= ovf_d;
    end
  end

  // Deliberately ignores load so cascaded stages see tc even while a load is pending.
  assign tc  = en & ((down == DIR_DOWN) ? (out_q == '0) : (out_q == MAX));
  assign out = out_q;
  assign ovf = ovf_q;

endmodule
